// File: rtl/operand_dispatcher_pkg.sv
// Shared stream definitions for multi-operand FPU front ends.
// This file holds the dispatcher state encoding and the packed {a, b} pair layout.
package operand_dispatcher_pkg;

    typedef enum logic {
        ACCEPT = 1'b0,
        SEND   = 1'b1
    } dispatch_state_e;

    localparam int PAIR_A        = 0;
    localparam int PAIR_B        = 1;
    localparam int PAIR_OPERANDS = 2;

    // Operand a occupies the upper half of a packed pair and b the lower half.
    function automatic int pair_lsb(input int width, input int operand);
        return (operand == PAIR_A) ? width : 0;
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Single-channel stb/ack output register with a done flag.
// The flag stays set until the parent clears it after the whole pair has completed.
module stream_out_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             clear_done,
    output logic [WIDTH-1:0] data,
    output logic             stb,
    input  logic             ack,
    output logic             fire,
    output logic             done
);

    assign fire = stb && ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            stb  <= 1'b0;
            done <= 1'b0;
        end else if (load) begin
            data <= load_data;
            stb  <= 1'b1;
            done <= 1'b0;
        end else begin
            if (fire) begin
                stb  <= 1'b0;
                done <= 1'b1;
            end
            // A clear on the completing edge overrides the set from that edge's own transfer.
            if (clear_done) begin
                done <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/operand_dispatcher.sv
// Splits one packed {a, b} operand stream into two independent stb/ack operand streams.
// A new pair is accepted only after both operands of the current pair have been delivered.
module operand_dispatcher
    import operand_dispatcher_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int COUNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2*WIDTH-1:0]   input_ab,
    input  logic                 input_ab_stb,
    output logic                 input_ab_ack,
    output logic [WIDTH-1:0]     output_a,
    output logic                 output_a_stb,
    input  logic                 output_a_ack,
    output logic [WIDTH-1:0]     output_b,
    output logic                 output_b_stb,
    input  logic                 output_b_ack,
    output logic [COUNT_W-1:0]   pairs_sent,
    output logic                 busy
);

    dispatch_state_e state_reg, state_next;
    logic input_ab_ack_reg, input_ab_ack_next;
    logic busy_reg, busy_next;
    logic [COUNT_W-1:0] pairs_sent_reg, pairs_sent_next;
    logic accept_fire, load, pair_done;

    logic [PAIR_OPERANDS-1:0] ch_ack, ch_stb, ch_fire, ch_done;
    logic [WIDTH-1:0]         ch_data [PAIR_OPERANDS];

    assign ch_ack[PAIR_A] = output_a_ack;
    assign ch_ack[PAIR_B] = output_b_ack;

    // Channel index matches PAIR_A/PAIR_B, so the slice follows the shared pair layout.
    generate
        for (genvar gi = 0; gi < PAIR_OPERANDS; gi++) begin : g_ch
            stream_out_reg #(.WIDTH(WIDTH)) u_ch (
                .clk        (clk),
                .rst        (rst),
                .load       (load),
                .load_data  (input_ab[pair_lsb(WIDTH, gi) +: WIDTH]),
                .clear_done (pair_done),
                .data       (ch_data[gi]),
                .stb        (ch_stb[gi]),
                .ack        (ch_ack[gi]),
                .fire       (ch_fire[gi]),
                .done       (ch_done[gi])
            );
        end
    endgenerate

    // input_ab_ack_reg is only ever high while in ACCEPT.
    assign accept_fire = input_ab_ack_reg && input_ab_stb;

    always_comb begin
        state_next        = state_reg;
        input_ab_ack_next = input_ab_ack_reg;
        pairs_sent_next   = pairs_sent_reg;
        load              = 1'b0;
        pair_done         = 1'b0;
        case (state_reg)
            ACCEPT: begin
                input_ab_ack_next = 1'b1;
                if (accept_fire) begin
                    load              = 1'b1;
                    input_ab_ack_next = 1'b0;
                    state_next        = SEND;
                end
            end
            SEND: begin
                input_ab_ack_next = 1'b0;
                if (&(ch_done | ch_fire)) begin
                    pair_done         = 1'b1;
                    pairs_sent_next   = pairs_sent_reg + COUNT_W'(1);
                    input_ab_ack_next = 1'b1;
                    state_next        = ACCEPT;
                end
            end
            default: state_next = ACCEPT;
        endcase
        busy_next = (state_next == SEND);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ACCEPT;
            input_ab_ack_reg <= 1'b0;
            busy_reg         <= 1'b0;
            pairs_sent_reg   <= '0;
        end else begin
            state_reg        <= state_next;
            input_ab_ack_reg <= input_ab_ack_next;
            busy_reg         <= busy_next;
            pairs_sent_reg   <= pairs_sent_next;
        end
    end

    assign input_ab_ack = input_ab_ack_reg;
    assign busy         = busy_reg;
    assign pairs_sent   = pairs_sent_reg;
    assign output_a     = ch_data[PAIR_A];
    assign output_a_stb = ch_stb[PAIR_A];
    assign output_b     = ch_data[PAIR_B];
    assign output_b_stb = ch_stb[PAIR_B];

endmodule

// File: tb/tb_operand_dispatcher.sv
// Bench for operand_dispatcher: table-driven pairs with per-operand ack delays,
// plus hand-written reset and mid-send reset sequences.
module tb_operand_dispatcher;

    localparam int WIDTH   = 16;
    localparam int COUNT_W = 4;
    localparam int CNT_MOD = 1 << COUNT_W;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [2*WIDTH-1:0]   input_ab;
    logic                 input_ab_stb;
    logic                 input_ab_ack;
    logic [WIDTH-1:0]     output_a;
    logic                 output_a_stb;
    logic                 output_a_ack;
    logic [WIDTH-1:0]     output_b;
    logic                 output_b_stb;
    logic                 output_b_ack;
    logic [COUNT_W-1:0]   pairs_sent;
    logic                 busy;

    int vectors    = 0;
    int miscompares = 0;
    int exp_count  = 0;

    typedef struct {
        logic [31:0] pair;
        int          da;
        int          db;
        bit          toggle;
    } vec_t;

    vec_t vecs_pre[$];
    vec_t vecs_post[$];

    operand_dispatcher #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .input_ab     (input_ab),
        .input_ab_stb (input_ab_stb),
        .input_ab_ack (input_ab_ack),
        .output_a     (output_a),
        .output_a_stb (output_a_stb),
        .output_a_ack (output_a_ack),
        .output_b     (output_b),
        .output_b_stb (output_b_stb),
        .output_b_ack (output_b_ack),
        .pairs_sent   (pairs_sent),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sink model: operand x is acked from cycle dx after the accept edge, so its stb
    // is visible up to and including cycle dx; the pair completes after max(da, db).
    task automatic send_pair(input logic [31:0] pair, input int da, input int db, input bit toggle);
        int n;
        int last;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        n = 0;
        exp_a = pair[31:16];
        exp_b = pair[15:0];
        last = (da > db) ? da : db;
        input_ab = pair;
        input_ab_stb = 1'b1;
        while (!input_ab_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", {31'b0, input_ab_ack}, 32'd1);
        @(negedge clk);
        input_ab_stb = 1'b0;
        for (int k = 0; k <= last + 1; k++) begin
            check("a_stb",  {31'b0, output_a_stb}, {31'b0, (k <= da)});
            check("b_stb",  {31'b0, output_b_stb}, {31'b0, (k <= db)});
            check("a_data", {16'b0, output_a}, {16'b0, exp_a});
            check("b_data", {16'b0, output_b}, {16'b0, exp_b});
            check("in_ack", {31'b0, input_ab_ack}, {31'b0, (k > last)});
            check("busy",   {31'b0, busy}, {31'b0, (k <= last)});
            check("pairs_sent", {28'b0, pairs_sent}, (k > last) ? (exp_count + 1) % CNT_MOD : exp_count);
            if (k <= last) begin
                output_a_ack = (k >= da);
                output_b_ack = (k >= db);
                if (toggle) begin
                    input_ab_stb = 1'($urandom_range(0, 1));
                    input_ab = $urandom;
                end
                @(negedge clk);
            end else begin
                output_a_ack = 1'b0;
                output_b_ack = 1'b0;
                input_ab_stb = 1'b0;
            end
        end
        exp_count = (exp_count + 1) % CNT_MOD;
        $display("pair 0x%08h da=%0d db=%0d toggle=%0d pairs_sent=%0d", pair, da, db, toggle, pairs_sent);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_in_ack"}, {31'b0, input_ab_ack}, 32'd0);
        check({tag, "_a_stb"},  {31'b0, output_a_stb}, 32'd0);
        check({tag, "_b_stb"},  {31'b0, output_b_stb}, 32'd0);
        check({tag, "_a_data"}, {16'b0, output_a}, 32'd0);
        check({tag, "_b_data"}, {16'b0, output_b}, 32'd0);
        check({tag, "_pairs"},  {28'b0, pairs_sent}, 32'd0);
        check({tag, "_busy"},   {31'b0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        input_ab = '0;
        input_ab_stb = 1'b0;
        output_a_ack = 1'b0;
        output_b_ack = 1'b0;

        vecs_pre.push_back('{32'h3C00_4000, 0, 0, 1'b0});
        vecs_pre.push_back('{32'hC000_3800, 0, 3, 1'b0});
        vecs_pre.push_back('{32'h3C00_4000, 0, 0, 1'b0});
        vecs_pre.push_back('{32'h4200_3C00, 1, 0, 1'b0});
        vecs_pre.push_back('{32'h7C00_0000, 0, 0, 1'b0});
        vecs_pre.push_back('{32'h5555_AAAA, 2, 2, 1'b1});
        vecs_post.push_back('{32'h1234_5678, 0, 0, 1'b0});
        for (int i = 0; i < 19; i++) begin
            vecs_post.push_back('{$urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                                  1'($urandom_range(0, 1))});
        end

        // Reset state and first ack after release.
        repeat (2) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;
        check("ack_at_release", {31'b0, input_ab_ack}, 32'd0);
        @(negedge clk);
        check("ack_after_release", {31'b0, input_ab_ack}, 32'd1);

        foreach (vecs_pre[i]) begin
            send_pair(vecs_pre[i].pair, vecs_pre[i].da, vecs_pre[i].db, vecs_pre[i].toggle);
        end

        // Asynchronous reset after a has transferred but b is still pending.
        input_ab = 32'hABCD_1111;
        input_ab_stb = 1'b1;
        @(negedge clk);
        input_ab_stb = 1'b0;
        check("mid_a_data", {16'b0, output_a}, 32'h0000_ABCD);
        output_a_ack = 1'b1;
        @(negedge clk);
        output_a_ack = 1'b0;
        check("mid_a_stb", {31'b0, output_a_stb}, 32'd0);
        check("mid_b_stb", {31'b0, output_b_stb}, 32'd1);
        #2 rst = 1'b1;
        #1 check_cleared("async_reset");
        $display("async reset mid-send: a_stb=%0d b_stb=%0d pairs_sent=%0d", output_a_stb, output_b_stb, pairs_sent);
        @(negedge clk);
        rst = 1'b0;
        exp_count = 0;

        foreach (vecs_post[i]) begin
            send_pair(vecs_post[i].pair, vecs_post[i].da, vecs_post[i].db, vecs_post[i].toggle);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/operand_dispatcher.md
Name: operand_dispatcher

Overview:
- Producer end of the stb/ack stream protocol used by the FPU cores (divider, etc.).
- Accepts one packed operand pair {a, b} on a single input stream and drives it out as two independent operand streams, output_a and output_b, wired to a core's input_a and input_b ports.
- Each output completes its own handshake independently; the next pair is accepted only after both operands are delivered.
- Replaces the pair of independent operand sources in synthesizable systems, so a single upstream source can feed any two-operand FPU core.

Parameters:
- WIDTH, 16, operand width in bits (16 = half precision).
- COUNT_W, 16, width of the delivered-pair counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- input_ab  input  2*WIDTH  packed pair: a = [2*WIDTH-1:WIDTH], b = [WIDTH-1:0].
- input_ab_stb  input  1  upstream pair valid.
- input_ab_ack  output  1  dispatcher ready for a pair.
- output_a  output  WIDTH  operand a to core.
- output_a_stb  output  1  operand a valid.
- output_a_ack  input  1  core accepts a.
- output_b  output  WIDTH  operand b to core.
- output_b_stb  output  1  operand b valid.
- output_b_ack  input  1  core accepts b.
- pairs_sent  output  COUNT_W  number of fully delivered pairs, wraps modulo 2^COUNT_W.
- busy  output  1  high in SEND state.

Behaviour:
- Transfer rule: a transfer occurs on a rising clk edge where stb and ack are both high. A sender holds stb and data stable until that edge, and an acker never depends combinationally on stb. All outputs are registered.
- Reset (async, any time, including mid-SEND): input_ab_ack=0, output_a_stb=0, output_b_stb=0, output_a=0, output_b=0, pairs_sent=0, busy=0, a_done=b_done=0, state=ACCEPT. An in-flight pair is discarded and is not counted.
- ACCEPT state:
  - On the first edge after reset release, input_ab_ack goes to 1. It stays high until a transfer occurs.
  - On the transfer edge: latch a into output_a and b into output_b; set input_ab_ack=0, output_a_stb=1, output_b_stb=1, busy=1; go to SEND.
  - Latency: both output stbs are high in the cycle immediately after the input transfer.
- SEND state:
  - On an output_a transfer edge: output_a_stb goes to 0 and a_done is set. The same rule applies to b.
  - Acks arriving on different edges are handled independently. A repeated or held ack after done has no effect.
  - Pair completion occurs on the edge where the last pending operand transfers, including when both transfer on the same edge. On that edge: pairs_sent increments by 1 (wrapping from 2^COUNT_W-1 to 0), a_done and b_done clear, busy goes to 0, input_ab_ack goes to 1, state goes to ACCEPT.
  - No pipelining: the minimum pair period is 2 cycles, one accept edge and one send edge.
- input_ab_stb is ignored outside ACCEPT. input_ab may change freely while input_ab_ack=0.
- Output data holds its value after stb drops until the next accepted pair.

Decomposition:
- Shared fpu stream package holds:
  - the state encoding constants ACCEPT=0 and SEND=1;
  - a helper constant or function giving the packed-pair field positions, so other multi-operand blocks share the {a, b} layout.
- One natural sub-module: stream_out_reg, a single-channel register with stb/ack/done flag. It is instantiated twice (a and b), with a parent FSM and counter. Total RTL is about 150-200 lines.

Test Plan:
1. Reset release, then input_ab=0x3C00_4000 with stb held high and both acks held high. Required response: ack=1 one cycle after reset; output_a=0x3C00 and output_b=0x4000 with both stbs high one cycle after the accept edge; both stbs drop on the next edge; pairs_sent=1; input_ab_ack=1 again.
2. Skewed acks: output_b_ack raised 3 cycles after output_a_ack, using pair 0xC000_3800. Required response: output_a_stb drops first; output_b_stb stays high until its ack edge; input_ab_ack stays 0 throughout; pairs_sent increments only on the b edge.
3. Back-to-back stream into a divider-model sink: 0x3C00/0x4000, 0x4200/0x3C00, 0x7C00/0x0000. Required response: delivered in order with no loss or duplication; pairs_sent=3.
4. Reset asserted asynchronously mid-SEND, after a is delivered but b is pending. Required response: outputs clear immediately without waiting for clk; pairs_sent=0; after release, a new pair 0x1234_5678 is accepted normally.
5. Counter wrap with COUNT_W=4: deliver 17 pairs. Required response: pairs_sent reads 15 after pair 15, then 0, then 1.
6. Upstream toggles input_ab_stb and input_ab while in SEND. Required response: no change to output_a or output_b and no extra count.
